// File: rtl/elastic_pkg.sv
// -----------------------------------------------------------------------------
// elastic_pkg
// Shared definitions for the elastic (valid/ready) buffer family.
//   elastic_state_e : occupancy FSM state, encoding doubles as the word count
//                     (EMPTY=0, BUSY=1, FULL=2) so it can be exported directly.
// No ports (package).
// -----------------------------------------------------------------------------
package elastic_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } elastic_state_e;

endpackage : elastic_pkg

// File: rtl/pipe_buffer.sv
// -----------------------------------------------------------------------------
// pipe_buffer
// Two-entry skid buffer on a valid/ready stream. Every output is driven
// straight from a flop, so there is no combinational path from input to
// output. out_reg feeds the downstream port; skid_reg catches the word that
// arrives in the cycle the downstream stalls.
//
// Ports:
//   i_clock       in   clock, rising edge
//   i_reset_n     in   asynchronous active-low reset
//   i_data        in   [DWIDTH] upstream payload
//   i_data_valid  in   upstream payload valid
//   o_data_ready  out  buffer can accept a word (flop)
//   o_data        out  [DWIDTH] downstream payload (flop)
//   o_data_valid  out  downstream payload valid (flop)
//   o_occupancy   out  [2] words held, 0/1/2 (flop), only with
//                      PIPE_BUFFER_OCCUPANCY_EN defined
//   i_data_ready  in   downstream can accept
//
// Build option: define PIPE_BUFFER_OCCUPANCY_EN to add o_occupancy.
// -----------------------------------------------------------------------------
module pipe_buffer
    import elastic_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_data_valid,
`ifdef PIPE_BUFFER_OCCUPANCY_EN
    output logic [1:0]        o_occupancy,
`endif
    input  logic              i_data_ready
);

    elastic_state_e    state_q, state_d;
    logic [DWIDTH-1:0] out_q,   out_d;
    logic [DWIDTH-1:0] skid_q,  skid_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;

    logic in_hs;
    logic out_hs;

    assign in_hs  = i_data_valid & ready_q;
    assign out_hs = valid_q & i_data_ready;

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (in_hs) state_d = BUSY;
            end
            BUSY: begin
                if (in_hs && !out_hs)      state_d = FULL;
                else if (!in_hs && out_hs) state_d = EMPTY;
            end
            FULL: begin
                // ready_q is low here, so only the drain side can move
                if (out_hs) state_d = BUSY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output / datapath next values. valid and ready are derived from the
    // next state so they are registered alongside it.
    always_comb begin
        out_d   = out_q;
        skid_d  = skid_q;
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != FULL);
        unique case (state_q)
            EMPTY: begin
                if (in_hs) out_d = i_data;
            end
            BUSY: begin
                if (in_hs && out_hs) out_d  = i_data;
                else if (in_hs)      skid_d = i_data;
            end
            FULL: begin
                if (out_hs) out_d = skid_q;
            end
            default: ;
        endcase
    end

    // ready_q resets low and rises on the first edge after reset release
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign o_data       = out_q;
    assign o_data_valid = valid_q;
    assign o_data_ready = ready_q;

`ifdef PIPE_BUFFER_OCCUPANCY_EN
    logic [1:0] occ_q;

    // State encoding equals the word count
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= 2'(state_d);
        end
    end

    assign o_occupancy = occ_q;
`endif

endmodule : pipe_buffer
